alu_result_collector: RTL and testbench
=======================================

ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter NUM, default 100: results per batch; m_tlast marks the NUM-th result.
REQ-002 Parameter DEPTH, default 16, power of two: depth of the tag queue and of the result FIFO.
REQ-003 Parameter TIMEOUT, default 255: idle cycles allowed while ops are outstanding.
REQ-004 clk_i  in  1  the only clock; all logic on its rising edge.
REQ-005 reset_i  in  1  reset, synchronous, active-low.
REQ-006 start_i  in  1  one-cycle pulse: a command was issued to the ALU BFM.
REQ-007 op_i  in  3  opcode of the command; valid when start_i=1.
REQ-008 done_i  in  1  one-cycle ALU completion pulse.
REQ-009 res_i  in  16  ALU result; valid when done_i=1.
REQ-010 m_tvalid  out  1  output stream valid.
REQ-011 m_tready  in  1  output stream ready.
REQ-012 m_tdata  out  16  result.
REQ-013 m_tuser  out  3  opcode paired with m_tdata.
REQ-014 m_tlast  out  1  last result of a batch.
REQ-015 pending_o  out  $clog2(DEPTH)+1  number of outstanding ops (in tag queue).
REQ-016 err_o  out  3  sticky flags: [0] spurious done, [1] overflow, [2] timeout.
REQ-017 checksum_o  out  16  running batch checksum (see Configuration).

Function
REQ-018 On start_i=1, push op_i into the tag queue; on done_i=1, pop the oldest tag and push {tag,res_i} into the result FIFO.
REQ-019 If start_i and done_i occur in the same cycle, pending_o stays unchanged; if the queue is empty, done pairs with the same-cycle op_i (bypass).
REQ-020 done_i with an empty queue and no same-cycle start_i: result dropped, err_o[0] set.
REQ-021 start_i with the queue full and no same-cycle done_i, or done_i with the result FIFO full and no same-cycle pop: the entry is dropped, err_o[1] set.
REQ-022 Latency: done_i in cycle N into an empty result FIFO yields m_tvalid=1 in cycle N+1.
REQ-023 Transfer occurs only when m_tvalid&&m_tready; m_tdata/m_tuser/m_tlast stay stable while m_tvalid=1 and m_tready=0.
REQ-024 Batch counter increments per transfer; m_tlast=1 when the counter equals NUM-1; the counter wraps to 0 after the transfer.
REQ-025 FSM states: IDLE (pending=0), BUSY (pending>0), STALLED.
REQ-026 FSM transitions: IDLE->BUSY on a push; BUSY->IDLE when pending reaches 0.
REQ-027 Timeout: in BUSY, a watchdog counts cycles without done_i; reaching TIMEOUT sets err_o[2], goes to STALLED and clears the tag queue.
REQ-028 The watchdog restarts on every done_i.
REQ-029 STALLED->IDLE on the next done_i or start_i; that event is handled as in IDLE.
REQ-030 err_o bits are sticky; only reset clears them.

Reset
REQ-031 When reset_i=0 at a clock edge: both FIFOs emptied, batch counter 0, watchdog 0, FSM IDLE.
REQ-032 Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, pending_o=0, err_o=0, checksum_o=0.
REQ-033 Reset mid-batch discards in-flight results; a done_i arriving after reset for a pre-reset op sets err_o[0].

Configuration
REQ-034 With COLLECTOR_CHECKSUM_EN defined, checksum_o is the 16-bit wrapping sum of m_tdata over transfers.
REQ-035 checksum_o shows the running sum including the current transfer, then clears to 0 in the cycle after the m_tlast transfer.
REQ-036 Without COLLECTOR_CHECKSUM_EN, checksum_o is constant 0 and no checksum logic is synthesised.

Structure
REQ-037 Package alu_tlm_pkg holds: alu_op_t (3-bit), alu_result_t struct {op, res}, collector_state_t enum, error-bit index constants.
REQ-038 Both queues instantiate one sub-module, sync_fifo, parameterised by width and depth, with full/empty flags and a count.

Verification
REQ-039 Three starts (op 1,2,3), then three dones (res 0x0010, 0x0020, 0x0030), m_tready=1 -> stream (1,0x0010),(2,0x0020),(3,0x0030) in order; pending_o goes 3->0.
REQ-040 NUM=4, 8 ops, m_tready=1 -> m_tlast on the 4th and 8th transfers only.
REQ-041 Simultaneous start_i (op 5) and done_i (res 0xBEEF) on an empty queue -> output (5,0xBEEF), pending_o stays 0, no error.
REQ-042 m_tready=0 with DEPTH+1 dones -> err_o[1]=1; the first DEPTH results drain intact.
REQ-043 TIMEOUT=10, one start and no done -> err_o[2]=1 at cycle 10, pending_o=0; a later done_i -> IDLE and err_o[0]=1.
REQ-044 COLLECTOR_CHECKSUM_EN defined, NUM=2, results 0xFFFF and 0x0002 -> checksum_o=0x0001 after the 2nd transfer, 0 one cycle later.

Source files
------------

// File: rtl/alu_tlm_pkg.sv
// Shared types for the ALU result collector: opcode/result pair, FSM states
// and the bit positions of the sticky error flags.
package alu_tlm_pkg;

  typedef logic [2:0] alu_op_t;

  typedef struct packed {
    alu_op_t     op;
    logic [15:0] res;
  } alu_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_STALLED
  } collector_state_t;

  localparam int ERR_SPURIOUS = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_TIMEOUT  = 2;

endpackage

// File: rtl/alu_result_collector_if.sv
// Output result stream of the collector: valid/ready handshake with the
// result data, its opcode tag and the end-of-batch marker.
interface alu_result_collector_if;
  import alu_tlm_pkg::*;

  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  alu_op_t     m_tuser;
  logic        m_tlast;

  modport master (output m_tvalid, m_tdata, m_tuser, m_tlast, input m_tready);
  modport slave  (input m_tvalid, m_tdata, m_tuser, m_tlast, output m_tready);

endinterface

// File: rtl/alu_result_collector_fifo.sv
// sync_fifo: single-clock FIFO with full/empty/count and a synchronous flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (!reset_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Pairs ALU completions with their issued opcodes and streams {op,result} in
// batches of NUM. Optional running checksum: define COLLECTOR_CHECKSUM_EN.
module alu_result_collector
  import alu_tlm_pkg::*;
#(
  parameter int NUM     = 100,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  alu_op_t                     op_i,
  input  logic                        done_i,
  input  logic [15:0]                 res_i,
  alu_result_collector_if.master      m_axis,
  output logic [$clog2(DEPTH):0]      pending_o,
  output logic [2:0]                  err_o,
  output logic [15:0]                 checksum_o
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int BW  = $clog2(NUM + 1);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);
  localparam logic [BW-1:0]  BATCH_LAST = BW'(NUM - 1);

  collector_state_t state_q;
  logic [WDW-1:0]   wdog_q;
  logic [BW-1:0]    batch_q;
  logic [2:0]       err_q, err_set;

  logic        tag_empty, tag_full, res_empty, res_full;
  logic [CW-1:0] tag_count, res_count_unused, pending_d;
  alu_op_t     tag_head;
  alu_result_t res_head, res_in;
  logic bypass, tag_push, tag_push_ok, tag_pop, res_push;
  logic timeout, transfer, tvalid, tlast;

  assign tvalid   = !res_empty;
  assign tlast    = tvalid && (batch_q == BATCH_LAST);
  assign transfer = tvalid && m_axis.m_tready;

  // A done with nothing queued takes its opcode straight from a same-cycle start.
  assign bypass      = start_i && done_i && tag_empty;
  assign timeout     = (state_q == ST_BUSY) && !done_i && (wdog_q == WD_LAST);
  assign tag_push    = start_i && !bypass && !timeout;
  assign tag_pop     = done_i && !tag_empty;
  assign tag_push_ok = tag_push && (!tag_full || tag_pop);
  assign res_push    = done_i && (!tag_empty || start_i);
  assign res_in      = '{op: (bypass ? op_i : tag_head), res: res_i};
  assign pending_d   = tag_count + CW'(tag_push_ok) - CW'(tag_pop);

  always_comb begin
    err_set               = '0;
    err_set[ERR_SPURIOUS] = done_i && tag_empty && !start_i;
    err_set[ERR_OVERFLOW] = (start_i && tag_full && !done_i)
                          || (res_push && res_full && !transfer);
    err_set[ERR_TIMEOUT]  = timeout;
  end

  sync_fifo #(.WIDTH($bits(alu_op_t)), .DEPTH(DEPTH)) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (timeout),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .data_i  (op_i),
    .data_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  sync_fifo #(.WIDTH($bits(alu_result_t)), .DEPTH(DEPTH)) u_res_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .push_i  (res_push),
    .pop_i   (transfer),
    .data_i  (res_in),
    .data_o  (res_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count_unused)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      batch_q <= '0;
      err_q   <= '0;
    end else begin
      err_q <= err_q | err_set;
      if (transfer) batch_q <= tlast ? '0 : batch_q + 1'b1;
      unique case (state_q)
        ST_BUSY: begin
          if (timeout) begin
            state_q <= ST_STALLED;
            wdog_q  <= '0;
          end else begin
            wdog_q <= (done_i || pending_d == '0) ? '0 : wdog_q + 1'b1;
            if (pending_d == '0) state_q <= ST_IDLE;
          end
        end
        ST_STALLED: begin
          if (start_i || done_i) state_q <= (pending_d != '0) ? ST_BUSY : ST_IDLE;
        end
        default: begin
          if (pending_d != '0) state_q <= ST_BUSY;
        end
      endcase
    end
  end

  assign m_axis.m_tvalid = tvalid;
  assign m_axis.m_tdata  = tvalid ? res_head.res : '0;
  assign m_axis.m_tuser  = tvalid ? res_head.op : '0;
  assign m_axis.m_tlast  = tlast;
  assign pending_o       = tag_count;
  assign err_o           = err_q;

`ifdef COLLECTOR_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        sum_clr_q;

  // The sum of a finished batch stays visible for one cycle before clearing.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sum_q     <= '0;
      sum_clr_q <= 1'b0;
    end else begin
      sum_clr_q <= transfer && tlast;
      if (transfer)       sum_q <= (sum_clr_q ? 16'h0 : sum_q) + m_axis.m_tdata;
      else if (sum_clr_q) sum_q <= '0;
    end
  end

  assign checksum_o = sum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench: dut (NUM=4, DEPTH=4, TIMEOUT=10) covers pairing, batching,
// overflow, reset and timeout; dut2 (NUM=2) covers the checksum sequence.
module tb_alu_result_collector;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0, done_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [15:0] res_i = '0;
  logic [2:0]  pending_o;
  logic [2:0]  err_o;
  logic [15:0] checksum_o;

  logic        start2 = 1'b0, done2 = 1'b0;
  logic [2:0]  op2 = '0;
  logic [15:0] res2 = '0;
  logic [2:0]  pending2;
  logic [2:0]  err2;
  logic [15:0] checksum2;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef COLLECTOR_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  alu_result_collector_if axis ();
  alu_result_collector_if axis2 ();

  always #5 clk = ~clk;

  alu_result_collector #(.NUM(4), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .done_i     (done_i),
    .res_i      (res_i),
    .m_axis     (axis.master),
    .pending_o  (pending_o),
    .err_o      (err_o),
    .checksum_o (checksum_o)
  );

  alu_result_collector #(.NUM(2), .DEPTH(4), .TIMEOUT(255)) dut2 (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start2),
    .op_i       (op2),
    .done_i     (done2),
    .res_i      (res2),
    .m_axis     (axis2.master),
    .pending_o  (pending2),
    .err_o      (err2),
    .checksum_o (checksum2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic [2:0] op, input logic d, input logic [15:0] r);
    start_i = s; op_i = op; done_i = d; res_i = r;
    @(posedge clk); #1;
    start_i = 1'b0; done_i = 1'b0;
  endtask

  task automatic cyc2(input logic s, input logic [2:0] op, input logic d, input logic [15:0] r);
    start2 = s; op2 = op; done2 = d; res2 = r;
    @(posedge clk); #1;
    start2 = 1'b0; done2 = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    axis.m_tready  = 1'b1;
    axis2.m_tready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    check("rst_tvalid",   axis.m_tvalid, 0);
    check("rst_tlast",    axis.m_tlast, 0);
    check("rst_tdata",    axis.m_tdata, 0);
    check("rst_tuser",    axis.m_tuser, 0);
    check("rst_pending",  pending_o, 0);
    check("rst_err",      err_o, 0);
    check("rst_checksum", checksum_o, 0);

    // Three ops issued, then completed in order
    cyc(1, 3'd1, 0, 16'h0);      check("ord_pend1", pending_o, 1);
    cyc(1, 3'd2, 0, 16'h0);      check("ord_pend2", pending_o, 2);
    cyc(1, 3'd3, 0, 16'h0);      check("ord_pend3", pending_o, 3);
    cyc(0, 3'd0, 1, 16'h0010);
    check("ord_valid1", axis.m_tvalid, 1);
    check("ord_data1",  axis.m_tdata, 16'h0010);
    check("ord_user1",  axis.m_tuser, 1);
    check("ord_pend_a", pending_o, 2);
    cyc(0, 3'd0, 1, 16'h0020);
    check("ord_data2",  axis.m_tdata, 16'h0020);
    check("ord_user2",  axis.m_tuser, 2);
    check("ord_pend_b", pending_o, 1);
    cyc(0, 3'd0, 1, 16'h0030);
    check("ord_data3",  axis.m_tdata, 16'h0030);
    check("ord_user3",  axis.m_tuser, 3);
    check("ord_pend_c", pending_o, 0);
    check("ord_last3",  axis.m_tlast, 0);
    cyc(0, 3'd0, 0, 16'h0);
    check("ord_drained", axis.m_tvalid, 0);

    // Same-cycle start/done on empty queue; this is the 4th result of the batch
    cyc(1, 3'd5, 1, 16'hBEEF);
    check("byp_data", axis.m_tdata, 16'hBEEF);
    check("byp_user", axis.m_tuser, 5);
    check("byp_pend", pending_o, 0);
    check("byp_err",  err_o, 0);
    check("byp_last", axis.m_tlast, 1);
    cyc(0, 3'd0, 0, 16'h0);

    // Eight back-to-back results: tlast on the 4th and 8th only
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 3'(k), 1, 16'(16'h0200 + k));
      check($sformatf("bat_data%0d", k), axis.m_tdata, 16'h0200 + k);
      check($sformatf("bat_last%0d", k), axis.m_tlast, (k == 4 || k == 8) ? 1 : 0);
    end
    cyc(0, 3'd0, 0, 16'h0);
    check("bat_err", err_o, 0);

    // Result FIFO overflow with the sink stalled
    axis.m_tready = 1'b0;
    for (int k = 1; k <= 5; k++) cyc(1, 3'(k), 1, 16'(16'h0100 + k));
    check("ovf_err",   err_o, 3'b010);
    check("ovf_hold",  axis.m_tdata, 16'h0101);
    check("ovf_huser", axis.m_tuser, 1);
    axis.m_tready = 1'b1;
    cyc(0, 3'd0, 0, 16'h0);      check("ovf_d2", axis.m_tdata, 16'h0102);
    cyc(0, 3'd0, 0, 16'h0);      check("ovf_d3", axis.m_tdata, 16'h0103);
    cyc(0, 3'd0, 0, 16'h0);
    check("ovf_d4",    axis.m_tdata, 16'h0104);
    check("ovf_last4", axis.m_tlast, 1);
    cyc(0, 3'd0, 0, 16'h0);      check("ovf_empty", axis.m_tvalid, 0);

    // Reset with an op outstanding and a result queued
    axis.m_tready = 1'b0;
    cyc(1, 3'd7, 0, 16'h0);
    cyc(1, 3'd1, 1, 16'h0077);
    check("mid_user", axis.m_tuser, 7);
    check("mid_pend", pending_o, 1);
    do_reset();
    check("mid_rst_valid", axis.m_tvalid, 0);
    check("mid_rst_pend",  pending_o, 0);
    check("mid_rst_err",   err_o, 0);
    cyc(0, 3'd0, 1, 16'h0099);
    check("mid_spur_err",   err_o, 3'b001);
    check("mid_spur_valid", axis.m_tvalid, 0);

    // Watchdog: one op, no completion
    axis.m_tready = 1'b1;
    do_reset();
    cyc(1, 3'd6, 0, 16'h0);
    for (int k = 0; k < 9; k++) cyc(0, 3'd0, 0, 16'h0);
    check("to_before_err",  err_o, 0);
    check("to_before_pend", pending_o, 1);
    cyc(0, 3'd0, 0, 16'h0);
    check("to_err",  err_o, 3'b100);
    check("to_pend", pending_o, 0);
    cyc(0, 3'd0, 1, 16'h0055);
    check("to_late_err",   err_o, 3'b101);
    check("to_late_valid", axis.m_tvalid, 0);
    cyc(1, 3'd3, 1, 16'h0033);
    check("to_recov_data", axis.m_tdata, 16'h0033);
    check("to_recov_user", axis.m_tuser, 3);

    // Checksum sequence on the NUM=2 instance
    cyc2(1, 3'd1, 1, 16'hFFFF);
    check("cs_first_data", axis2.m_tdata, 16'hFFFF);
    check("cs_before",     checksum2, 0);
    cyc2(1, 3'd2, 1, 16'h0002);
    check("cs_run1",  checksum2, CSUM_EN ? 16'hFFFF : 16'h0);
    check("cs_last2", axis2.m_tlast, 1);
    cyc2(0, 3'd0, 0, 16'h0);
    check("cs_total", checksum2, CSUM_EN ? 16'h0001 : 16'h0);
    cyc2(0, 3'd0, 0, 16'h0);
    check("cs_clear", checksum2, 0);
    check("cs_err",   err2, 0);
    check("cs_pend",  pending2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
